// File: rtl/allocator_slot_if.sv
// Bundle between the pixel broadcaster / MAC side and one allocator slot.
// The master modport is the controlling side; the slot uses the slave modport.
interface allocator_slot_if;
    logic        load;
    logic [7:0]  load_cx;
    logic [7:0]  load_cy;
    logic [1:0]  load_pad;
    logic [8:0]  z_max;
    logic        issue_en;
    logic [7:0]  issue_x;
    logic [7:0]  issue_y;
    logic [17:0] issue_data;
    logic        issue_done;
    logic        issue_block;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic [13:0] out_widx;
    logic        slot_busy;
    logic        slot_done;
    logic        err_overflow;
    logic        err_short;

    modport master (
        output load, load_cx, load_cy, load_pad, z_max,
        output issue_en, issue_x, issue_y, issue_data, issue_done, out_ready,
        input  issue_block, out_valid, out_data, out_widx,
        input  slot_busy, slot_done, err_overflow, err_short
    );

    modport slave (
        input  load, load_cx, load_cy, load_pad, z_max,
        input  issue_en, issue_x, issue_y, issue_data, issue_done, out_ready,
        output issue_block, out_valid, out_data, out_widx,
        output slot_busy, slot_done, err_overflow, err_short
    );
endinterface

// File: rtl/allocator_slot.sv
// One filter-window slot: snoops the broadcast pixel bus, captures beats inside
// its window and streams {pixel, weight index} to the MAC through a small FIFO.
module allocator_slot #(
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    allocator_slot_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] P_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] P_BLOCK = (AW+1)'(FIFO_DEPTH - 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_cx;
    logic [7:0]  r_cy;
    logic [1:0]  r_pad;
    logic [8:0]  r_zMax;
    logic [13:0] r_capCount;
    logic [13:0] r_chanCount;
    logic [13:0] r_zBase;
    logic        r_errOverflow;
    logic        r_errShort;

    logic [17:0] r_memData [FIFO_DEPTH];
    logic [13:0] r_memWidx [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;

    logic [3:0]  w_size;
    logic [13:0] w_win;
    logic [13:0] w_total;
    logic        w_inX;
    logic        w_inY;
    logic [7:0]  w_dx;
    logic [7:0]  w_dy;
    logic [13:0] w_widx;
    logic        w_loadAccept;
    logic        w_capture;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic [13:0] w_capNext;
    logic        w_chanWrap;

    assign w_size  = {1'b0, r_pad, 1'b0} + 4'd1;
    assign w_win   = 14'(w_size) * 14'(w_size);
    assign w_total = w_win * (14'(r_zMax) + 14'd1);

    // Window test done with the pad moved to the pixel side so cx < pad never wraps.
    assign w_inX = (({1'b0, bus.issue_x} + {7'b0, r_pad}) >= {1'b0, r_cx}) &&
                   ({1'b0, bus.issue_x} <= ({1'b0, r_cx} + {7'b0, r_pad}));
    assign w_inY = (({1'b0, bus.issue_y} + {7'b0, r_pad}) >= {1'b0, r_cy}) &&
                   ({1'b0, bus.issue_y} <= ({1'b0, r_cy} + {7'b0, r_pad}));

    assign w_dx   = bus.issue_x + {6'b0, r_pad} - r_cx;
    assign w_dy   = bus.issue_y + {6'b0, r_pad} - r_cy;
    assign w_widx = r_zBase + 14'(w_dy) * 14'(w_size) + 14'(w_dx);

    assign w_loadAccept = bus.load && ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                          (bus.load_pad != 2'd3);
    assign w_capture    = (r_state == S_COLLECT) && bus.issue_en && w_inX && w_inY;
    assign w_full       = (r_count == P_FULL);
    assign w_pop        = (r_count != '0) && bus.out_ready;
    assign w_push       = w_capture && (!w_full || w_pop);
    assign w_capNext    = r_capCount + {13'b0, w_capture};
    assign w_chanWrap   = ((r_chanCount + 14'd1) == w_win);

    assign bus.issue_block  = (r_state == S_COLLECT) && (r_count >= P_BLOCK);
    assign bus.out_valid    = (r_count != '0);
    assign bus.out_data     = r_memData[r_rdPtr];
    assign bus.out_widx     = r_memWidx[r_rdPtr];
    assign bus.slot_busy    = (r_state == S_COLLECT) || (r_state == S_DRAIN);
    assign bus.slot_done    = (r_state == S_DONE);
    assign bus.err_overflow = r_errOverflow;
    assign bus.err_short    = r_errShort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cx          <= '0;
            r_cy          <= '0;
            r_pad         <= '0;
            r_zMax        <= '0;
            r_capCount    <= '0;
            r_chanCount   <= '0;
            r_zBase       <= '0;
            r_errOverflow <= 1'b0;
            r_errShort    <= 1'b0;
        end else if (w_loadAccept) begin
            r_state       <= S_COLLECT;
            r_cx          <= bus.load_cx;
            r_cy          <= bus.load_cy;
            r_pad         <= bus.load_pad;
            r_zMax        <= bus.z_max;
            r_capCount    <= '0;
            r_chanCount   <= '0;
            r_zBase       <= '0;
            r_errOverflow <= 1'b0;
            r_errShort    <= 1'b0;
        end else begin
            case (r_state)
                S_COLLECT: begin
                    if (w_capture) begin
                        r_capCount <= w_capNext;
                        if (w_chanWrap) begin
                            r_chanCount <= '0;
                            r_zBase     <= r_zBase + w_win;
                        end else begin
                            r_chanCount <= r_chanCount + 14'd1;
                        end
                    end
                    if (w_capture && w_full && !w_pop) begin
                        r_errOverflow <= 1'b1;
                    end
                    if ((w_capNext == w_total) || bus.issue_done) begin
                        r_state <= S_DRAIN;
                        if (w_capNext < w_total) begin
                            r_errShort <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_count == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memData[r_wrPtr] <= bus.issue_data;
            r_memWidx[r_wrPtr] <= w_widx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: doc/allocator_slot.md
ALLOCATOR_SLOT -- requirements
Module: allocator_slot

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, capture FIFO depth in entries (min 4, power of two).
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load  input  1  start new filter position (one-cycle pulse).
REQ-005 SHALL have ports load_cx, load_cy  input  8 each  filter centre, padded image coordinates.
REQ-006 SHALL have port load_pad  input  2  filter half-width: 0=1x1, 1=3x3, 2=5x5; 3 reserved.
REQ-007 SHALL have port z_max  input  9  last channel index, sampled on accepted load.
REQ-008 SHALL have ports issue_en  input  1, issue_x  input  8, issue_y  input  8, issue_data  input  18  broadcast pixel bus.
REQ-009 SHALL have port issue_done  input  1  broadcaster finished the round.
REQ-010 SHALL have port issue_block  output  1  stall request to broadcaster.
REQ-011 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  18, out_widx  output  14  pixel/weight-index stream to MAC.
REQ-012 SHALL have ports slot_busy  output  1, slot_done  output  1, err_overflow  output  1, err_short  output  1.

Function
REQ-013 SHALL implement states IDLE, COLLECT, DRAIN, DONE.
REQ-014 SHALL accept load only in IDLE or DONE with load_pad != 3, latching cx, cy, pad, z_max, clearing counters and error flags, entering COLLECT next cycle; load otherwise ignored.
REQ-015 SHALL define size = 2*pad+1, win = size*size, total = win*(z_max+1); counters at least 14 bits.
REQ-016 SHALL, in COLLECT, capture a beat when issue_en=1 and cx-pad <= issue_x <= cx+pad and cy-pad <= issue_y <= cy+pad, compared in 9-bit signed-safe arithmetic (no underflow wrap when cx < pad).
REQ-017 SHALL compute dx = issue_x-(cx-pad), dy = issue_y-(cy-pad), widx = z*win + dy*size + dx, truncated to 14 bits.
REQ-018 SHALL track z as a capture counter: after win captures within a channel, z increments and in-channel count clears.
REQ-019 SHALL push {issue_data, widx} into FIFO on each capture; out_valid = FIFO non-empty; head drives out_data/out_widx; pop on out_valid && out_ready.
REQ-020 SHALL, on simultaneous push and pop, keep occupancy unchanged and preserve order.
REQ-021 SHALL deliver a captured beat on out_* the cycle after capture when FIFO was empty (latency 1).
REQ-022 SHALL drive issue_block = 1 combinationally when occupancy >= FIFO_DEPTH-2 in COLLECT, else 0 (2-entry headroom for in-flight beats).
REQ-023 SHALL, on a capture while FIFO full, drop the beat and set err_overflow sticky until next accepted load or rst.
REQ-024 SHALL move COLLECT -> DRAIN when capture count reaches total, or on issue_done=1 (that cycle's capture still taken); if count < total after that cycle, set err_short sticky.
REQ-025 SHALL move DRAIN -> DONE when FIFO empty and no push pending; ignore issue_en in DRAIN, DONE, IDLE.
REQ-026 SHALL assert slot_busy in COLLECT and DRAIN; slot_done = 1 only in DONE, held until accepted load.
REQ-027 SHALL drive issue_block = 0 outside COLLECT.

Reset
REQ-028 SHALL, on rst, enter IDLE, empty FIFO, clear counters, and drive issue_block, out_valid, slot_busy, slot_done, err_overflow, err_short to 0; rst mid-COLLECT discards all captured data.
REQ-029 SHALL give rst priority over load and all other inputs in the same cycle.

Verification
REQ-030 3x3 load cx=5,cy=5,z_max=0, raster sweep x,y 0..9, out_ready=1 -> exactly 9 beats, widx 0..8 in order, first at (4,4), then DONE, err flags 0.
REQ-031 5x5 load cx=2,cy=2 (pad=2), z_max=1, sweep 0..6 twice -> 50 beats, widx 0..49, no capture with x or y > 4, no underflow match.
REQ-032 out_ready=0, FIFO_DEPTH=4, continuous matching beats -> issue_block rises at occupancy 2, no overflow when broadcaster stalls one cycle later; out_ready=1 drains in order.
REQ-033 Force 5 matching beats ignoring issue_block into full FIFO -> err_overflow=1 sticky, FIFO contents intact.
REQ-034 issue_done after 4 of 9 captures -> DRAIN, 4 beats out, DONE, err_short=1; load mid-COLLECT ignored; rst mid-COLLECT -> IDLE, out_valid=0 next cycle.
